nn_eval_sequencer: RTL and testbench

NN_EVAL_SEQUENCER -- requirements
Module: nn_eval_sequencer

---
 rtl/nn_eval_sequencer.sv | 106 ++++++++++
 tb/tb_nn_eval_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_eval_sequencer.sv
// Steps a 2-input network through the four XOR truth-table patterns, samples each
// result against a signed threshold and scores the predictions against XOR.
module nn_eval_sequencer #(
   parameter int                            DATA_WIDTH    = 16,
   parameter int                            SETTLE_CYCLES = 2,
   parameter logic signed [DATA_WIDTH-1:0]  THRESHOLD     = 16'sh0800
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic signed [DATA_WIDTH-1:0]  nn_output,
   output logic [1:0]                    nn_inputs,
   output logic                          busy,
   output logic                          done,
   output logic [3:0]                    preds,
   output logic [2:0]                    error_count,
   output logic                          pass
);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

   // APPLY preloads SETTLE_CYCLES-1 so SETTLE exits when the counter reads zero.
   localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   state_t      state;
   state_t      state_next;
   logic [1:0]  index;
   logic [3:0]  settle_cnt;
   logic        prediction;
   logic        expected;
   logic [2:0]  err_next;

   assign prediction = (nn_output >= THRESHOLD);
   assign expected   = nn_inputs[1] ^ nn_inputs[0];
   assign err_next   = ((prediction != expected) && (error_count != 3'd4)) ?
                       error_count + 3'd1 : error_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE) && (state != DONE);
      done       = (state == DONE);
      case (state)
         IDLE:    if (start) state_next = APPLY;
         APPLY:   state_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
         SETTLE:  if (settle_cnt == 4'd0) state_next = SAMPLE;
         SAMPLE:  state_next = (index == 2'd3) ? DONE : APPLY;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pass and the idle input pattern are settled on entry to DONE so they are
   // already valid while the done pulse is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index       <= 2'd0;
         settle_cnt  <= 4'd0;
         nn_inputs   <= 2'b00;
         preds       <= 4'b0000;
         error_count <= 3'd0;
         pass        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  index       <= 2'd0;
                  nn_inputs   <= 2'b00;
                  preds       <= 4'b0000;
                  error_count <= 3'd0;
                  pass        <= 1'b0;
               end
            end
            APPLY: begin
               settle_cnt <= SETTLE_LOAD;
            end
            SETTLE: begin
               if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
            end
            SAMPLE: begin
               preds[index] <= prediction;
               error_count  <= err_next;
               if (index == 2'd3) begin
                  pass      <= (err_next == 3'd0);
                  nn_inputs <= 2'b00;
               end else begin
                  index     <= index + 2'd1;
                  nn_inputs <= index + 2'd1;
               end
            end
            DONE: begin
               nn_inputs <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Scoreboard bench for nn_eval_sequencer: the default instance and a SETTLE_CYCLES=0
// instance are driven by behavioural network models; a monitor scores each done pulse.
module tb_nn_eval_sequencer;

   typedef struct {
      logic [3:0] preds;
      logic [2:0] err;
      logic       pass;
      int         cyc;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               start_a, start_b;
   logic signed [15:0] nn_out_a, nn_out_b;
   logic [1:0]         nn_inputs_a, nn_inputs_b;
   logic               busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [3:0]         preds_a, preds_b;
   logic [2:0]         err_a, err_b;

   int   mode_a, mode_b;
   int   cyc;
   int   checks;
   int   failures;
   exp_t sb_a[$];
   exp_t sb_b[$];

   nn_eval_sequencer dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .nn_output(nn_out_a),
      .nn_inputs(nn_inputs_a), .busy(busy_a), .done(done_a),
      .preds(preds_a), .error_count(err_a), .pass(pass_a)
   );

   nn_eval_sequencer #(.SETTLE_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .nn_output(nn_out_b),
      .nn_inputs(nn_inputs_b), .busy(busy_b), .done(done_b),
      .preds(preds_b), .error_count(err_b), .pass(pass_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Network models: 0 ideal XOR, 1 stuck at 1.0, 2 threshold-edge table, 3 inverted XOR.
   function automatic logic signed [15:0] model(input int m, input logic [1:0] p);
      logic signed [15:0] r;
      r = 16'sh0000;
      case (m)
         0: r = (p[1] ^ p[0]) ? 16'sh1000 : 16'sh0000;
         1: r = 16'sh1000;
         2: case (p)
               2'd0:    r = 16'sh0800;
               2'd1:    r = 16'sh07FF;
               2'd2:    r = 16'shF000;
               default: r = 16'sh0000;
            endcase
         default: r = (p[1] ^ p[0]) ? 16'sh0000 : 16'sh1000;
      endcase
      return r;
   endfunction

   always_comb nn_out_a = model(mode_a, nn_inputs_a);
   always_comb nn_out_b = model(mode_b, nn_inputs_b);

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && done_a) begin
         if (sb_a.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL a_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
         end else begin
            e = sb_a.pop_front();
            check_output("a_done_cycle", cyc, e.cyc);
            check_output("a_preds", preds_a, e.preds);
            check_output("a_error_count", err_a, e.err);
            check_output("a_pass", pass_a, e.pass);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && done_b) begin
         if (sb_b.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
         end else begin
            e = sb_b.pop_front();
            check_output("b_done_cycle", cyc, e.cyc);
            check_output("b_preds", preds_b, e.preds);
            check_output("b_error_count", err_b, e.err);
            check_output("b_pass", pass_b, e.pass);
         end
      end
   end

   // Bounded wait for the scoreboard of one instance to drain; optional start re-pulses.
   task automatic wait_drain(input int dut, input int s, input bit repulse);
      for (int i = 0; i < 60; i++) begin
         if (((dut == 0) ? sb_a.size() : sb_b.size()) == 0) break;
         @(negedge clk);
         if (repulse) start_a = (cyc == s + 3) || (cyc == s + 10);
         if (cyc == s + 5) check_output("busy_mid_run", (dut == 0) ? busy_a : busy_b, 1);
      end
      if (((dut == 0) ? sb_a.size() : sb_b.size()) != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL run_timeout: got no done expected done by cycle %0d", s + 16);
         if (dut == 0) sb_a.delete(); else sb_b.delete();
      end
      start_a = 1'b0;
   endtask

   // Must be called just after a falling edge; the next rising edge samples start.
   task automatic apply_stimulus(input int dut, input int m, input logic [3:0] p,
                                 input logic [2:0] e, input logic ps, input bit repulse);
      int   s;
      exp_t x;
      s       = cyc + 1;
      x.preds = p;
      x.err   = e;
      x.pass  = ps;
      x.cyc   = s + ((dut == 0) ? 16 : 8);
      if (dut == 0) begin
         mode_a = m;
         sb_a.push_back(x);
         start_a = 1'b1;
      end else begin
         mode_b = m;
         sb_b.push_back(x);
         start_b = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      wait_drain(dut, s, repulse);
      repeat (3) @(negedge clk);
      check_output("hold_preds", (dut == 0) ? preds_a : preds_b, p);
      check_output("hold_error_count", (dut == 0) ? err_a : err_b, e);
      check_output("hold_pass", (dut == 0) ? pass_a : pass_b, ps);
      check_output("idle_busy", (dut == 0) ? busy_a : busy_b, 0);
      check_output("idle_nn_inputs", (dut == 0) ? nn_inputs_a : nn_inputs_b, 0);
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_nn_inputs"}, nn_inputs_a, 0);
      check_output({tag, "_busy"}, busy_a, 0);
      check_output({tag, "_done"}, done_a, 0);
      check_output({tag, "_preds"}, preds_a, 0);
      check_output({tag, "_error_count"}, err_a, 0);
      check_output({tag, "_pass"}, pass_a, 0);
   endtask

   initial begin
      int   s;
      exp_t x;
      checks   = 0;
      failures = 0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      mode_a   = 0;
      mode_b   = 0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      apply_stimulus(0, 0, 4'b0110, 3'd0, 1'b1, 1'b0);
      apply_stimulus(0, 1, 4'b1111, 3'd2, 1'b0, 1'b0);
      apply_stimulus(0, 2, 4'b0001, 3'd3, 1'b0, 1'b0);
      apply_stimulus(0, 3, 4'b1001, 3'd4, 1'b0, 1'b0);
      apply_stimulus(0, 0, 4'b0110, 3'd0, 1'b1, 1'b1);

      // Abort a run during SETTLE of pattern 2; nothing is queued for it.
      mode_a  = 0;
      s       = cyc + 1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      while (cyc < s + 9) @(negedge clk);
      check_output("mid_run_busy", busy_a, 1);
      check_output("mid_run_nn_inputs", nn_inputs_a, 2);
      #2 rst_n = 1'b0;
      #1 check_reset_state("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(0, 0, 4'b0110, 3'd0, 1'b1, 1'b0);

      // Start held high across a run relaunches two cycles after the done pulse.
      s       = cyc + 1;
      x.preds = 4'b0110;
      x.err   = 3'd0;
      x.pass  = 1'b1;
      x.cyc   = s + 16;
      sb_a.push_back(x);
      x.cyc   = s + 34;
      sb_a.push_back(x);
      start_a = 1'b1;
      repeat (20) @(negedge clk);
      start_a = 1'b0;
      wait_drain(0, s + 18, 1'b0);

      apply_stimulus(1, 0, 4'b0110, 3'd0, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
